// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the debug/CPU RAM arbiter.
//   arb_state_e : arbiter FSM state encoding
//   GapCntW     : width of the post-access CPU gap down-counter
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHold,
        StAccess,
        StDone,
        StGap
    } arb_state_e;

    localparam int unsigned GapCntW = 4;

endpackage

// File: rtl/ram_mux.sv
// Combinational RAM address/data/strobe mux for the debug arbiter.
// Ports:
//   clk                    in  system clock, used to form the write strobe
//   state                  in  current arbiter state
//   dbg_wr/addr/wdata      in  latched debug access
//   cpu_addr/we/oe/dout    in  CPU-side RAM controls
//   ram_addr/wdata/we/oe   out RAM-side controls
module ram_mux
    import ram_arbiter_pkg::*;
(
    input  logic        clk,
    input  arb_state_e  state,
    input  logic        dbg_wr,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_oe,
    input  logic [7:0]  cpu_dout,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_oe
);

    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_dout;
        ram_we    = 1'b0;
        ram_oe    = 1'b0;
        case (state)
            StIdle, StGap: begin
                // Write strobe is the high phase of the clock, as on the CPU side.
                ram_we = clk & cpu_we;
                ram_oe = cpu_oe;
            end
            StHold: begin
                ram_addr = dbg_addr;
                ram_oe   = ~dbg_wr;
            end
            StAccess: begin
                ram_addr  = dbg_addr;
                ram_wdata = dbg_wdata;
                ram_we    = clk & dbg_wr;
                ram_oe    = ~dbg_wr;
            end
            default: begin
                // StDone: RAM is quiet for one cycle while the CPU is still held.
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Debug-port RAM arbiter: steals RAM cycles from the CPU by asserting hold.
// Ports:
//   clk, rst_n             in  clock, asynchronous active-low reset
//   cpu_addr/we/oe/dout    in  CPU-side RAM controls
//   dbg_req/wr/addr/wdata  in  debug request (level) and access, sampled at accept
//   ram_rdata              in  RAM read data
//   hold                   out freezes CPU clock enables (registered)
//   ram_addr/wdata/we/oe   out RAM-side controls
//   dbg_ack                out one-cycle completion pulse
//   dbg_rdata              out debug read result
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned MIN_CPU_GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_oe,
    input  logic [7:0]  cpu_dout,
    input  logic        dbg_req,
    input  logic        dbg_wr,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    input  logic [7:0]  ram_rdata,
    output logic        hold,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic        ram_oe,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata
);

    arb_state_e         state_q;
    logic [GapCntW-1:0] gap_cnt_q;
    logic               hold_q;
    logic               ack_q;
    logic [7:0]         rdata_q;
    logic               wr_q;
    logic [15:0]        addr_q;
    logic [7:0]         wdata_q;
    logic               mux_we;

    // GAP occupies exactly MIN_CPU_GAP cycles; a request that is still held
    // is then accepted from the following IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gap_cnt_q <= '0;
            hold_q    <= 1'b0;
            ack_q     <= 1'b0;
            rdata_q   <= 8'h00;
            wr_q      <= 1'b0;
            addr_q    <= 16'h0000;
            wdata_q   <= 8'h00;
        end else begin
            case (state_q)
                StIdle: begin
                    if (dbg_req && (gap_cnt_q == '0)) begin
                        wr_q    <= dbg_wr;
                        addr_q  <= dbg_addr;
                        wdata_q <= dbg_wdata;
                        hold_q  <= 1'b1;
                        state_q <= StHold;
                    end
                end
                StHold: begin
                    state_q <= StAccess;
                end
                StAccess: begin
                    if (!wr_q) begin
                        rdata_q <= ram_rdata;
                    end
                    ack_q   <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    ack_q  <= 1'b0;
                    hold_q <= 1'b0;
                    if (MIN_CPU_GAP > 0) begin
                        gap_cnt_q <= GapCntW'(MIN_CPU_GAP);
                        state_q   <= StGap;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StGap: begin
                    if (gap_cnt_q <= GapCntW'(1)) begin
                        gap_cnt_q <= '0;
                        state_q   <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GapCntW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    ram_mux u_ram_mux (
        .clk       (clk),
        .state     (state_q),
        .dbg_wr    (wr_q),
        .dbg_addr  (addr_q),
        .dbg_wdata (wdata_q),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_oe    (cpu_oe),
        .cpu_dout  (cpu_dout),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (mux_we),
        .ram_oe    (ram_oe)
    );

    // Keep the write strobe dead for the whole reset pulse, not just after
    // the state register has settled.
    assign ram_we    = mux_we & rst_n;
    assign hold      = hold_q;
    assign dbg_ack   = ack_q;
    assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter (MIN_CPU_GAP = 2).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_oe;
    logic [7:0]  cpu_dout;
    logic        dbg_req;
    logic        dbg_wr;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [7:0]  ram_rdata;
    logic        hold;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic        ram_oe;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;

    int total  = 0;
    int passed = 0;

    // Small RAM model: 256 bytes, indexed by the low address byte.
    logic [7:0] mem [0:255] = '{default: 8'h00};
    always @(posedge ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    assign ram_rdata = mem[ram_addr[7:0]];

    ram_arbiter #(
        .MIN_CPU_GAP (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_we    (cpu_we),
        .cpu_oe    (cpu_oe),
        .cpu_dout  (cpu_dout),
        .dbg_req   (dbg_req),
        .dbg_wr    (dbg_wr),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .ram_rdata (ram_rdata),
        .hold      (hold),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic check_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge (clock high phase).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] exp_hold;
    logic [11:0] exp_ack;

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = 16'h5555;
        cpu_we    = 1'b0;
        cpu_oe    = 1'b1;
        cpu_dout  = 8'h33;
        dbg_req   = 1'b0;
        dbg_wr    = 1'b0;
        dbg_addr  = 16'h0000;
        dbg_wdata = 8'h00;

        // Reset state
        tick();
        check_b("rst_hold", hold, 1'b0);
        check_b("rst_ack", dbg_ack, 1'b0);
        check_w("rst_rdata", {8'h00, dbg_rdata}, 16'h0000);
        check_b("rst_we", ram_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: CPU owns the RAM, write strobe follows the clock high phase
        tick();
        check_w("idle_addr", ram_addr, 16'h5555);
        check_w("idle_wdata", {8'h00, ram_wdata}, 16'h0033);
        check_b("idle_oe", ram_oe, 1'b1);
        check_b("idle_we0", ram_we, 1'b0);
        @(negedge clk);
        cpu_we = 1'b1;
        tick();
        check_b("idle_we_hi", ram_we, 1'b1);
        #5;
        check_b("idle_we_lowphase", ram_we, 1'b0);
        cpu_we = 1'b0;

        // Debug write 0123 <- A5, accepted at the next edge k
        @(negedge clk);
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'h0123; dbg_wdata = 8'hA5;
        tick();                                    // k+1 HOLD
        check_b("wr_hold_k1", hold, 1'b1);
        check_w("wr_addr_k1", ram_addr, 16'h0123);
        check_b("wr_we_k1", ram_we, 1'b0);
        check_b("wr_oe_k1", ram_oe, 1'b0);
        tick();                                    // k+2 ACCESS
        check_b("wr_hold_k2", hold, 1'b1);
        check_w("wr_addr_k2", ram_addr, 16'h0123);
        check_w("wr_data_k2", {8'h00, ram_wdata}, 16'h00A5);
        check_b("wr_we_k2", ram_we, 1'b1);
        check_b("wr_ack_k2", dbg_ack, 1'b0);
        tick();                                    // k+3 DONE
        check_b("wr_ack_k3", dbg_ack, 1'b1);
        check_b("wr_hold_k3", hold, 1'b1);
        check_b("wr_we_k3", ram_we, 1'b0);
        check_b("wr_oe_k3", ram_oe, 1'b0);
        @(negedge clk);
        dbg_req = 1'b0; dbg_wr = 1'b0; dbg_addr = 16'h0000; dbg_wdata = 8'h00;
        tick();                                    // k+4 GAP
        check_b("wr_hold_k4", hold, 1'b0);
        check_b("wr_ack_k4", dbg_ack, 1'b0);
        check_w("wr_rdata_kept", {8'h00, dbg_rdata}, 16'h0000);
        tick();                                    // GAP
        tick();                                    // IDLE
        check_w("gap_idle_addr", ram_addr, 16'h5555);

        // Debug read of 0123 with CPU_WE held and request dropped in HOLD
        @(negedge clk);
        dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 16'h0123;
        cpu_we = 1'b1; cpu_addr = 16'h0124;
        tick();                                    // HOLD
        check_b("rd_hold_h", hold, 1'b1);
        check_b("rd_we_h", ram_we, 1'b0);
        check_w("rd_addr_h", ram_addr, 16'h0123);
        check_b("rd_oe_h", ram_oe, 1'b1);
        @(negedge clk);
        dbg_req = 1'b0; dbg_addr = 16'hFFFF;
        tick();                                    // ACCESS
        check_b("rd_we_a", ram_we, 1'b0);
        check_w("rd_addr_a", ram_addr, 16'h0123);
        check_b("rd_ack_a", dbg_ack, 1'b0);
        tick();                                    // DONE
        check_b("rd_ack_d", dbg_ack, 1'b1);
        check_w("rd_rdata", {8'h00, dbg_rdata}, 16'h00A5);
        check_b("rd_we_d", ram_we, 1'b0);
        check_b("rd_oe_d", ram_oe, 1'b0);
        @(negedge clk);
        cpu_we = 1'b0;
        for (int i = 0; i < 4; i++) begin           // GAP, GAP, IDLE, IDLE
            tick();
            check_b("rd_no_second_ack", dbg_ack, 1'b0);
            check_b("rd_no_second_hold", hold, 1'b0);
        end

        // Held request with gap 2: CPU writes get through the GAP cycles
        @(negedge clk);
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 8'h11;
        cpu_we = 1'b1; cpu_addr = 16'h0300; cpu_dout = 8'h77;
        // cycles 1..12: H A D G G I H A D G G I (bit i-1)
        exp_hold = 12'b000111000111;
        exp_ack  = 12'b000100000100;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check_b("held_hold_seq", hold, exp_hold[i-1]);
            check_b("held_ack_seq", dbg_ack, exp_ack[i-1]);
            if (i == 4 || i == 5 || i == 10 || i == 11) begin
                check_b("gap_cpu_we", ram_we, 1'b1);
                check_w("gap_cpu_addr", ram_addr, 16'h0300);
            end
            if (i == 11) begin
                @(negedge clk);
                dbg_req = 1'b0; cpu_we = 1'b0;
            end
        end

        // Reset in ACCESS aborts a write to FFFF
        @(negedge clk);
        dbg_req = 1'b1; dbg_wr = 1'b1; dbg_addr = 16'hFFFF; dbg_wdata = 8'h99;
        cpu_addr = 16'h1234;
        tick();                                    // HOLD
        tick();                                    // ACCESS
        check_w("ffff_addr", ram_addr, 16'hFFFF);
        check_b("abort_we_pre", ram_we, 1'b1);
        #1;
        rst_n = 1'b0;
        dbg_req = 1'b0;
        #1;
        check_b("abort_hold", hold, 1'b0);
        check_b("abort_ack", dbg_ack, 1'b0);
        check_b("abort_we", ram_we, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_b("post_rst_hold", hold, 1'b0);
        check_w("post_rst_addr", ram_addr, 16'h1234);
        tick();
        check_b("post_rst_ack", dbg_ack, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
